ebus_diag_sequencer: RTL and testbench

Synthesizable controller that owns the EBUS diagnostic-function lines (ds, diag strobe, RH data, driving) and shares them between NREQ requesters, e.g. the master-reset sequencer and the DTE. Each request is one diagnostic function: a plain function, a write with RH data, or a read that captures EBUS data. The block enforces fixed strobe-assert and recovery timing and arbitrates round-robin. It sits between the front-end requesters and the CLK/EBUS diagnostic decode.

---
 rtl/ebus_diag_sequencer_if.sv | 31 +++
 rtl/ebus_diag_sequencer.sv | 154 +++++++++++++++
 tb/tb_ebus_diag_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebus_diag_sequencer_if.sv
// rtl/ebus_diag_sequencer_if.sv - requester and EBUS diagnostic signal bundle
interface ebus_diag_sequencer_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [7*NREQ-1:0]  req_func;
   logic [NREQ-1:0]    req_write;
   logic [NREQ-1:0]    req_read;
   logic [18*NREQ-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    req_done;
   logic [35:0]        rdata;
   logic [6:0]         ebus_ds;
   logic               ebus_diag_strobe;
   logic [17:0]        ebus_data_out;
   logic               ebus_driving;
   logic [35:0]        ebus_data_in;
   logic               busy;

   modport master (
      output req_valid, req_func, req_write, req_read, req_data, ebus_data_in,
      input  req_ready, req_done, rdata, ebus_ds, ebus_diag_strobe,
             ebus_data_out, ebus_driving, busy
   );

   modport slave (
      input  req_valid, req_func, req_write, req_read, req_data, ebus_data_in,
      output req_ready, req_done, rdata, ebus_ds, ebus_diag_strobe,
             ebus_data_out, ebus_driving, busy
   );
endinterface

// File: rtl/ebus_diag_sequencer.sv
// rtl/ebus_diag_sequencer.sv - round-robin owner of the EBUS diagnostic strobe lines
module ebus_diag_sequencer #(
   parameter int         NREQ           = 2,
   parameter int         STROBE_CYCLES  = 9,
   parameter int         RECOVER_CYCLES = 4,
   parameter logic [6:0] DS_IDLE        = 7'o000
) (
   input logic                  clk,
   input logic                  reset,
   ebus_diag_sequencer_if.slave bus
);
   localparam int MAX_CYCLES = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] STROBE_LOAD  = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_CYCLES - 1);
   localparam logic [IW-1:0] LAST_INIT    = IW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, ASSERT, RECOVER} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            read_q, read_d;
   logic [6:0]      ds_q, ds_d;
   logic            strobe_q, strobe_d;
   logic            drive_q, drive_d;
   logic [17:0]     dout_q, dout_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [35:0]     rdata_q, rdata_d;

   logic            grant_found;
   logic [IW-1:0]   grant_idx;
   logic [IW:0]     cand;
   logic [NREQ-1:0] ready_c;

   // Round-robin search starting just after the last accepted requester.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, last_q} + (IW+1)'(k + 1);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!grant_found && bus.req_valid[cand[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      ready_c = '0;
      if (state_q == IDLE && !reset && grant_found) begin
         ready_c[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      idx_d    = idx_q;
      read_d   = read_q;
      ds_d     = ds_q;
      strobe_d = strobe_q;
      drive_d  = drive_q;
      dout_d   = dout_q;
      done_d   = '0;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               state_d  = ASSERT;
               cnt_d    = STROBE_LOAD;
               last_d   = grant_idx;
               idx_d    = grant_idx;
               read_d   = bus.req_read[grant_idx];
               ds_d     = bus.req_func[7*grant_idx +: 7];
               strobe_d = 1'b1;
               drive_d  = bus.req_write[grant_idx];
               dout_d   = bus.req_write[grant_idx] ? bus.req_data[18*grant_idx +: 18] : 18'd0;
            end
         end
         ASSERT: begin
            if (cnt_q == '0) begin
               // All EBUS lines drop together as the strobe ends.
               if (read_q) begin
                  rdata_d = bus.ebus_data_in;
               end
               state_d       = RECOVER;
               cnt_d         = RECOVER_LOAD;
               ds_d          = DS_IDLE;
               strobe_d      = 1'b0;
               drive_d       = 1'b0;
               dout_d        = 18'd0;
               done_d[idx_q] = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RECOVER: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= LAST_INIT;
         idx_q    <= '0;
         read_q   <= 1'b0;
         ds_q     <= DS_IDLE;
         strobe_q <= 1'b0;
         drive_q  <= 1'b0;
         dout_q   <= 18'd0;
         done_q   <= '0;
         rdata_q  <= 36'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         read_q   <= read_d;
         ds_q     <= ds_d;
         strobe_q <= strobe_d;
         drive_q  <= drive_d;
         dout_q   <= dout_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.req_ready        = ready_c;
   assign bus.req_done         = done_q;
   assign bus.rdata            = rdata_q;
   assign bus.ebus_ds          = ds_q;
   assign bus.ebus_diag_strobe = strobe_q;
   assign bus.ebus_data_out    = dout_q;
   assign bus.ebus_driving     = drive_q;
   assign bus.busy             = (state_q != IDLE);
endmodule

// File: tb/tb_ebus_diag_sequencer.sv
// tb/tb_ebus_diag_sequencer.sv - randomized self-checking bench for ebus_diag_sequencer
module tb_ebus_diag_sequencer;
   localparam int SA = 9;
   localparam int RA = 4;
   localparam int SB = 1;
   localparam int RB = 1;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ebus_diag_sequencer_if #(.NREQ(2)) ia();
   ebus_diag_sequencer_if #(.NREQ(2)) ib();

   ebus_diag_sequencer #(.NREQ(2), .STROBE_CYCLES(SA), .RECOVER_CYCLES(RA), .DS_IDLE(7'o000))
      dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   ebus_diag_sequencer #(.NREQ(2), .STROBE_CYCLES(SB), .RECOVER_CYCLES(RB), .DS_IDLE(7'o000))
      dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req_a(input int i, input logic [6:0] f, input logic w, input logic r,
                            input logic [17:0] d);
      ia.req_valid[i]         = 1'b1;
      ia.req_func[7*i +: 7]   = f;
      ia.req_write[i]         = w;
      ia.req_read[i]          = r;
      ia.req_data[18*i +: 18] = d;
   endtask

   task automatic clear_a;
      ia.req_valid = '0;
      ia.req_write = '0;
      ia.req_read  = '0;
   endtask

   function automatic logic [35:0] rand36();
      return 36'({$urandom(), $urandom()});
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      ia.req_valid = 2'b11;
      tick();
      tick();
      n_tests++;
      if (ia.req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 00", ia.req_ready);
      end
      n_tests++;
      if ({ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy}
          !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outs_a got %h want 0",
                  {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy});
      end
      n_tests++;
      if (ia.rdata !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_rdata got %h want 0", ia.rdata);
      end
      n_tests++;
      if ({ib.ebus_diag_strobe, ib.ebus_ds, ib.req_done, ib.busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outs_b got %h want 0", {ib.ebus_diag_strobe, ib.ebus_ds, ib.req_done, ib.busy});
      end
      clear_a();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_write;
      logic [29:0] exp_v, act_v;
      set_req_a(0, 7'o044, 1'b1, 1'b0, 18'o000120);
      #1;
      n_tests++;
      if (ia.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL write_ready got %b want 01", ia.req_ready);
      end
      tick();
      clear_a();
      for (int t = 1; t <= SA + RA + 1; t++) begin
         if (t <= SA) exp_v = {1'b1, 7'o044, 1'b1, 18'o000120, 2'b00, 1'b1};
         else         exp_v = {1'b0, 7'o000, 1'b0, 18'd0, (t == SA + 1) ? 2'b01 : 2'b00, t <= SA + RA};
         act_v = {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL write_t%0d got %h want %h", t, act_v, exp_v);
         end
         if (t == SA + RA + 1) begin
            ia.req_valid[0] = 1'b1;
            #1;
            n_tests++;
            if (ia.req_ready !== 2'b01) begin
               n_fail++;
               $display("FAIL write_next_ready got %b want 01", ia.req_ready);
            end
            clear_a();
         end
         tick();
      end
   endtask

   task automatic test_read_capture;
      logic [29:0] exp_v, act_v;
      ia.ebus_data_in = rand36();
      set_req_a(1, 7'o162, 1'b0, 1'b1, 18'($urandom()));
      #1;
      n_tests++;
      if (ia.req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL read_ready got %b want 10", ia.req_ready);
      end
      tick();
      clear_a();
      for (int t = 1; t <= SA + RA + 1; t++) begin
         if (t <= SA) exp_v = {1'b1, 7'o162, 1'b0, 18'd0, 2'b00, 1'b1};
         else         exp_v = {1'b0, 7'o000, 1'b0, 18'd0, (t == SA + 1) ? 2'b10 : 2'b00, t <= SA + RA};
         act_v = {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL read_t%0d got %h want %h", t, act_v, exp_v);
         end
         if (t == SA + 1 || t == SA + RA + 1) begin
            n_tests++;
            if (ia.rdata !== 36'o000000000040) begin
               n_fail++;
               $display("FAIL read_rdata_t%0d got %o want 000000000040", t, ia.rdata);
            end
         end
         ia.ebus_data_in = (t == SA) ? 36'o000000000040 : rand36();
         tick();
      end
   endtask

   task automatic test_non_read;
      logic [29:0] exp_v, act_v;
      set_req_a(0, 7'o010, 1'b0, 1'b0, 18'($urandom()));
      tick();
      clear_a();
      for (int t = 1; t <= SA + RA + 1; t++) begin
         if (t <= SA) exp_v = {1'b1, 7'o010, 1'b0, 18'd0, 2'b00, 1'b1};
         else         exp_v = {1'b0, 7'o000, 1'b0, 18'd0, (t == SA + 1) ? 2'b01 : 2'b00, t <= SA + RA};
         act_v = {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL nonread_t%0d got %h want %h", t, act_v, exp_v);
         end
         ia.ebus_data_in = rand36();
         tick();
      end
      n_tests++;
      if (ia.rdata !== 36'o000000000040) begin
         n_fail++;
         $display("FAIL nonread_rdata got %o want 000000000040", ia.rdata);
      end
   endtask

   // Model: one function at a time, timeline measured from its accept cycle.
   task automatic test_round_robin;
      logic [6:0]  rf[2];
      logic        rw[2], rr[2];
      logic [17:0] rd[2];
      logic [6:0]  p_func;
      logic        p_w, p_r;
      logic [17:0] p_d;
      int          p_idx, last_g, acc_c, c, n_acc, t, winner;
      logic [35:0] exp_rdata, din, din_cap;
      logic [29:0] exp_v, act_v;
      logic [1:0]  exp_ready;
      int          g_hist[$], acc_hist[$], done_hist[$];

      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_g = 1; acc_c = -(SA + RA + 1); c = 0; n_acc = 0;
      p_func = '0; p_w = 0; p_r = 0; p_d = '0; p_idx = 0;
      exp_rdata = '0; din_cap = '0;
      for (int i = 0; i < 2; i++) begin
         rf[i] = 7'($urandom()); rw[i] = 1'($urandom()); rr[i] = 1'($urandom()); rd[i] = 18'($urandom());
         set_req_a(i, rf[i], rw[i], rr[i], rd[i]);
      end
      while ((n_acc < 8 || c <= acc_c + SA + RA) && c < 400) begin
         t = c - acc_c;
         if (t >= 1 && t <= SA) exp_v = {1'b1, p_func, p_w, p_w ? p_d : 18'd0, 2'b00, 1'b1};
         else exp_v = {1'b0, 7'o000, 1'b0, 18'd0, (t == SA + 1) ? 2'(2'b01 << p_idx) : 2'b00,
                       t >= 1 && t <= SA + RA};
         if (t == SA + 1 && p_r) exp_rdata = din_cap;
         act_v = {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL rr_outs_c%0d got %h want %h", c, act_v, exp_v);
         end
         n_tests++;
         if (ia.rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rr_rdata_c%0d got %h want %h", c, ia.rdata, exp_rdata);
         end
         if (ia.req_done !== 2'b00) done_hist.push_back(c);
         din = rand36();
         ia.ebus_data_in = din;
         if (t == SA) din_cap = din;
         if (t == 1) begin
            rf[p_idx] = 7'($urandom()); rw[p_idx] = 1'($urandom());
            rr[p_idx] = 1'($urandom()); rd[p_idx] = 18'($urandom());
            set_req_a(p_idx, rf[p_idx], rw[p_idx], rr[p_idx], rd[p_idx]);
         end
         if (n_acc >= 8) clear_a();
         #1;
         winner = (last_g + 1) % 2;
         exp_ready = (t >= SA + RA + 1 && n_acc < 8) ? 2'(2'b01 << winner) : 2'b00;
         n_tests++;
         if (ia.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rr_ready_c%0d got %b want %b", c, ia.req_ready, exp_ready);
         end
         if (exp_ready != 2'b00) begin
            acc_c = c; p_idx = winner; last_g = winner;
            p_func = rf[winner]; p_w = rw[winner]; p_r = rr[winner]; p_d = rd[winner];
            g_hist.push_back(winner); acc_hist.push_back(c); n_acc++;
         end
         tick();
         c++;
      end
      clear_a();
      n_tests++;
      if (n_acc != 8 || c >= 400) begin
         n_fail++;
         $display("FAIL rr_budget got %0d accepts in %0d cycles want 8", n_acc, c);
      end
      for (int k = 0; k < g_hist.size(); k++) begin
         n_tests++;
         if (g_hist[k] != k % 2) begin
            n_fail++;
            $display("FAIL rr_grant_%0d got %0d want %0d", k, g_hist[k], k % 2);
         end
      end
      for (int k = 1; k < acc_hist.size(); k++) begin
         n_tests++;
         if (acc_hist[k] - acc_hist[k-1] != SA + RA + 1) begin
            n_fail++;
            $display("FAIL rr_spacing_%0d got %0d want %0d", k, acc_hist[k] - acc_hist[k-1], SA + RA + 1);
         end
      end
      n_tests++;
      if (done_hist.size() != 8) begin
         n_fail++;
         $display("FAIL rr_done_count got %0d want 8", done_hist.size());
      end
      for (int k = 1; k < done_hist.size(); k++) begin
         n_tests++;
         if (done_hist[k] - done_hist[k-1] < SA + RA + 1) begin
            n_fail++;
            $display("FAIL rr_done_gap_%0d got %0d want >=%0d", k, done_hist[k] - done_hist[k-1], SA + RA + 1);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [6:0] f;
      int         bad;
      f = 7'($urandom_range(1, 127));
      set_req_a(0, f, 1'b1, 1'b1, 18'($urandom()));
      ia.ebus_data_in = rand36();
      tick();
      clear_a();
      for (int t = 2; t <= 5; t++) tick();
      n_tests++;
      if (ia.ebus_diag_strobe !== 1'b1 || ia.ebus_ds !== f) begin
         n_fail++;
         $display("FAIL rmid_strobe got %b/%o want 1/%o", ia.ebus_diag_strobe, ia.ebus_ds, f);
      end
      reset = 1'b1;
      set_req_a(0, f, 1'b0, 1'b0, '0);
      set_req_a(1, f, 1'b0, 1'b0, '0);
      #1;
      n_tests++;
      if (ia.req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL rmid_ready_in_reset got %b want 00", ia.req_ready);
      end
      tick();
      clear_a();
      reset = 1'b0;
      n_tests++;
      if ({ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy} !== 30'd0
          || ia.rdata !== 36'd0) begin
         n_fail++;
         $display("FAIL rmid_after got %h/%h want 0/0",
                  {ia.ebus_diag_strobe, ia.ebus_ds, ia.ebus_driving, ia.ebus_data_out, ia.req_done, ia.busy}, ia.rdata);
      end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (ia.req_done !== 2'b00 || ia.busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rmid_no_done got %0d active cycles want 0", bad);
      end
      f = 7'($urandom_range(1, 127));
      set_req_a(0, f, 1'b0, 1'b0, '0);
      set_req_a(1, 7'o077, 1'b0, 1'b0, '0);
      #1;
      n_tests++;
      if (ia.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rmid_priority got %b want 01", ia.req_ready);
      end
      tick();
      clear_a();
      n_tests++;
      if (ia.ebus_diag_strobe !== 1'b1 || ia.ebus_ds !== f) begin
         n_fail++;
         $display("FAIL rmid_restart got %b/%o want 1/%o", ia.ebus_diag_strobe, ia.ebus_ds, f);
      end
      for (int t = 2; t <= SA + 1; t++) tick();
      n_tests++;
      if (ia.req_done !== 2'b01) begin
         n_fail++;
         $display("FAIL rmid_done got %b want 01", ia.req_done);
      end
      for (int t = SA + 2; t <= SA + RA + 1; t++) tick();
   endtask

   task automatic test_fast;
      logic [10:0] exp_v, act_v;
      logic [1:0]  exp_ready;
      logic [6:0]  fx[2];
      int          ph, g;
      fx[0] = 7'o021;
      fx[1] = 7'o123;
      ib.req_valid = 2'b11;
      ib.req_func  = {fx[1], fx[0]};
      ib.req_write = 2'b00;
      ib.req_read  = 2'b00;
      ib.req_data  = '0;
      for (int c = 0; c < 12; c++) begin
         ph = c % (SB + RB + 1);
         g  = (c / (SB + RB + 1)) % 2;
         if (ph == 0)      exp_v = {1'b0, 7'o000, 2'b00, 1'b0};
         else if (ph == 1) exp_v = {1'b1, fx[g], 2'b00, 1'b1};
         else              exp_v = {1'b0, 7'o000, 2'(2'b01 << g), 1'b1};
         exp_ready = (ph == 0) ? 2'(2'b01 << g) : 2'b00;
         #1;
         act_v = {ib.ebus_diag_strobe, ib.ebus_ds, ib.req_done, ib.busy};
         n_tests++;
         if (act_v !== exp_v || ib.req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL fast_c%0d got %h/%b want %h/%b", c, act_v, ib.req_ready, exp_v, exp_ready);
         end
         tick();
      end
      ib.req_valid = 2'b00;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      ia.req_valid = '0; ia.req_func = '0; ia.req_write = '0; ia.req_read = '0;
      ia.req_data = '0; ia.ebus_data_in = '0;
      ib.req_valid = '0; ib.req_func = '0; ib.req_write = '0; ib.req_read = '0;
      ib.req_data = '0; ib.ebus_data_in = '0;
      test_reset();
      test_single_write();
      test_read_capture();
      test_non_read();
      test_round_robin();
      test_reset_mid();
      test_fast();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
